// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decode-side handshake bundle for fetch_queue.
//   f_valid/f_ready : fetch offers {f_instr, f_pc, f_pc4}; accepted when both high
//   d_valid/d_ready : decode consumes the head {d_instr, d_pc, d_pc4, d_adel}
// Modports: master = fetch/decode side (environment), slave = the queue itself.
interface fetch_queue_if;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic [31:0] f_pc4;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc4;
  logic        d_adel;

  modport master (
    output f_valid, f_instr, f_pc, f_pc4, d_ready,
    input  f_ready, d_valid, d_instr, d_pc, d_pc4, d_adel
  );

  modport slave (
    input  f_valid, f_instr, f_pc, f_pc4, d_ready,
    output f_ready, d_valid, d_instr, d_pc, d_pc4, d_adel
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: two-entry buffer between instruction fetch and decode.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears all state
//   flush - branch/jump redirect; empties the queue and drops any same-cycle push
//   fq    - fetch_queue_if.slave (fetch push side, decode pop side)
// Optional build macro: ADEL_CHECK_EN - flag misaligned fetch PCs; such entries
//   carry d_adel=1 and NOP_WORD as instruction. Undefined: d_adel tied low.
module fetch_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  fetch_queue_if.slave fq
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
  logic [31:0] pc_q    [2];
  logic [31:0] pc_d    [2];
  logic [31:0] pc4_q   [2];
  logic [31:0] pc4_d   [2];
`ifdef ADEL_CHECK_EN
  logic        adel_q  [2];
  logic        adel_d  [2];
`endif

  logic push;
  logic pop;
  logic empty;

  // Handshake outputs depend on registered count only; no d_ready -> f_ready path.
  assign empty      = (count_q == 2'd0);
  assign fq.f_ready = (count_q != FULL);
  assign fq.d_valid = ~empty;
  assign push       = fq.f_valid & fq.f_ready & ~flush;
  assign pop        = fq.d_valid & fq.d_ready;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
`ifdef ADEL_CHECK_EN
    adel_d   = adel_q;
`endif

    if (push) begin
      instr_d[wr_ptr_q] = fq.f_instr;
      pc_d[wr_ptr_q]    = fq.f_pc;
      pc4_d[wr_ptr_q]   = fq.f_pc4;
`ifdef ADEL_CHECK_EN
      adel_d[wr_ptr_q]  = (fq.f_pc[1:0] != 2'b00);
      if (fq.f_pc[1:0] != 2'b00) instr_d[wr_ptr_q] = NOP_WORD;
`endif
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) rd_ptr_d = ~rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Entry contents are left as-is on flush; d_valid=0 masks them.
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      instr_q  <= '{default: '0};
      pc_q     <= '{default: '0};
      pc4_q    <= '{default: '0};
`ifdef ADEL_CHECK_EN
      adel_q   <= '{default: 1'b0};
`endif
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
`ifdef ADEL_CHECK_EN
      adel_q   <= adel_d;
`endif
    end
  end

  assign fq.d_instr = empty ? NOP_WORD : instr_q[rd_ptr_q];
  assign fq.d_pc    = empty ? '0       : pc_q[rd_ptr_q];
  assign fq.d_pc4   = empty ? '0       : pc4_q[rd_ptr_q];
`ifdef ADEL_CHECK_EN
  assign fq.d_adel  = empty ? 1'b0     : adel_q[rd_ptr_q];
`else
  assign fq.d_adel  = 1'b0;
`endif

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Two-entry fetch buffer between the instruction fetch unit and the decode stage of the pipelined MIPS core. Each cycle it captures {instruction, PC, PC+4} from fetch under a valid/ready handshake, holds up to two fetched words while decode stalls, and presents the oldest one to decode. A flush input from branch/jump resolution discards every buffered word in one cycle.

## Interface
Parameters:
- DEPTH, 2, number of entries; fixed at 2, other values unsupported
- NOP_WORD, 32'h0000_0000, instruction value driven on d_instr when d_valid=0

Ports:
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset; clears all state immediately on assertion
- f_valid  in  1  fetch presents a word this cycle
- f_ready  out  1  buffer accepts a word this cycle; fetch holds its PC when low
- f_instr  in  32  fetched instruction
- f_pc  in  32  address of f_instr
- f_pc4  in  32  f_pc + 4 from fetch
- flush  in  1  redirect; discard all entries and any same-cycle push
- d_valid  out  1  head entry valid
- d_ready  in  1  decode consumes head entry this cycle
- d_instr  out  32  head instruction, NOP_WORD when empty
- d_pc  out  32  head PC, 0 when empty
- d_pc4  out  32  head PC+4, 0 when empty
- d_adel  out  1  head entry came from a misaligned PC (see Configuration)

## Operation
- Storage: two entry registers {instr, pc, pc4, adel}, read pointer, write pointer (1 bit each), count (2 bits, 0..2).
- push = f_valid & f_ready & ~flush; pop = d_valid & d_ready.
- f_ready = (count != 2); registered-state only, no combinational path from d_ready.
- d_valid = (count != 0); d_* driven from entry[rd_ptr], forced to NOP_WORD/0/0/0 when count==0.
- push: write entry[wr_ptr], wr_ptr toggles. pop: rd_ptr toggles. Pointers wrap 1->0.
- count: +1 on push only, -1 on pop only, unchanged on both.
- count==0 with push: word visible on d_* the next cycle (no bypass).
- count==1 push+pop: head replaced by the new word, count stays 1.
- count==2: no push possible; pop frees one slot, f_ready high next cycle.
- flush: count<=0, rd_ptr<=0, wr_ptr<=0 at the edge; flush overrides push and pop. Entry data not cleared (masked by d_valid).
- Reset low at any time: count, pointers, entries cleared asynchronously; d_valid=0, f_ready=1 while Reset low and after release.

## Timing
- Fetch-to-decode latency: 1 cycle when empty.
- Throughput: 1 word/cycle sustained while d_ready=1.
- Reset values: f_ready=1, d_valid=0, d_instr=NOP_WORD, d_pc=0, d_pc4=0, d_adel=0.
- Flush asserted in cycle N: d_valid=0 and f_ready=1 in cycle N+1; first post-redirect word pushed in N+1 appears in N+2.
- d_* change only at clock edges or on Reset assertion.

## Configuration
- ADEL_CHECK_EN defined: on push, if f_pc[1:0] != 2'b00, the entry stores adel=1 and instr=NOP_WORD (pc, pc4 kept as given); d_adel reflects the head entry.
- ADEL_CHECK_EN undefined: no alignment check; adel bits not implemented, d_adel tied 0, f_instr stored unchanged.

## Test plan
- Reset low mid-run with count=2 -> immediately d_valid=0, f_ready=1, d_instr=0; after release, push f_pc=0x00003000 -> next cycle d_pc=0x00003000, d_pc4=0x00003004.
- Stream 0x3000,0x3004,0x3008 with d_ready=1 -> d_pc sequence 0x3000,0x3004,0x3008 one cycle behind push, count never exceeds 1.
- d_ready=0, push 0x3000,0x3004,0x3008 -> f_ready drops after second push, third held by fetch; release d_ready -> outputs 0x3000,0x3004,0x3008 in order, none lost or duplicated.
- count=2 plus f_valid=1 and flush=1 same cycle -> next cycle d_valid=0, f_ready=1, pushed word absent; push 0x3040 -> d_pc=0x3040 following cycle.
- count=1 with push+pop same cycle -> count stays 1, d_pc becomes the new word, pointer wrap 1->0 exercised.
- ADEL_CHECK_EN defined, push f_pc=0x00003002, f_instr=0x24010001 -> d_adel=1, d_instr=0, d_pc=0x00003002; undefined -> d_adel=0, d_instr=0x24010001.
